line_buffer: RTL and testbench
==============================

# line_buffer

Single-entry 256-bit line buffer between the multicycle RV32I control/datapath memory port and a 64-bit burst physical memory. Accepts the CPU's level-held word requests (`mem_read`/`mem_write` held until `mem_resp`), serves reads that hit the buffered line in one cycle, and fills misses with a 4-beat burst. Writes are write-through at line granularity: the line is filled if needed, the bytes are merged, and the whole line is written back in a 4-beat burst.

## Interface
Parameters:
- none. Line and beat geometry are fixed constants in the shared package.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_address`  in  32  CPU byte address. Bits [4:2] select the word, bits [31:5] form the tag.
- `mem_read`  in  1  CPU read request, held until `mem_resp`.
- `mem_write`  in  1  CPU write request, held until `mem_resp`.
- `mem_byte_enable`  in  4  byte lanes for a write.
- `mem_wdata`  in  32  write data, already lane-aligned.
- `mem_rdata`  out  32  selected word of the buffer.
- `mem_resp`  out  1  one-cycle completion pulse.
- `pmem_address`  out  32  line-aligned burst address.
- `pmem_read`  out  1  burst read request, held for the whole burst.
- `pmem_write`  out  1  burst write request, held for the whole burst.
- `pmem_wdata`  out  64  current write beat.
- `pmem_rdata`  in  64  current read beat.
- `pmem_resp`  in  1  one beat accepted or returned this cycle.

## Operation
- Storage: `valid` (1 bit), `tag` (27 bits, `mem_address[31:5]`), `data` (256 bits), beat counter `cnt` (2 bits).
- A hit requires `valid` and `tag == mem_address[31:5]`.
- States and transitions:
  - IDLE
    - `mem_write` and hit → MERGE.
    - `mem_write` and miss → FILL.
    - `mem_read` and hit → RESP.
    - `mem_read` and miss → FILL.
    - No request → stay in IDLE.
    - If `mem_read` and `mem_write` are both asserted, the write takes priority.
  - FILL
    - `pmem_read=1`.
    - On each `pmem_resp`, `data[64*cnt +: 64] <= pmem_rdata` and `cnt` increments.
    - On the 4th beat: `valid<=1`, `tag<=mem_address[31:5]`, `cnt<=0`.
    - Then go to MERGE if the request is a write, otherwise to RESP.
  - MERGE
    - One cycle.
    - For each `i` with `mem_byte_enable[i]=1`, byte `i` of word `mem_address[4:2]` takes `mem_wdata[8i+7:8i]`.
    - Next state: WB.
  - WB
    - `pmem_write=1` and `pmem_wdata = data[64*cnt +: 64]`.
    - On each `pmem_resp`, `cnt` increments.
    - On the 4th beat: `cnt<=0`, next state RESP.
  - RESP
    - `mem_resp=1` for exactly one cycle.
    - Next state: IDLE, unconditionally.
- Outputs by state:
  - `pmem_address = {mem_address[31:5], 5'b0}` in FILL and WB, 0 otherwise.
  - `mem_rdata = data[32*mem_address[4:2] +: 32]` at all times. It is only meaningful while `mem_resp=1`.
- Requester contract: the request deasserts in the cycle after `mem_resp`, so IDLE never re-serves the same request.
- `pmem_resp` outside FILL/WB is ignored.
- Gaps between beats are allowed: `cnt` and all state hold while `pmem_resp=0`.
- Reset, including mid-burst:
  - State, `cnt` and `pmem_*` outputs: IDLE, `cnt=0`, all `pmem_*` outputs 0 immediately.
  - Buffer contents: `valid=0`, `tag=0`, `data=0`.
  - Response outputs: `mem_resp=0`, `mem_rdata=0`.
  - An interrupted burst is abandoned. The physical memory model must tolerate the dropped request.

## Timing
- Read hit: request seen in IDLE at cycle N → `mem_resp` at cycle N+1.
- Read miss: `pmem_read` from cycle N+1. Last beat at cycle M → `mem_resp` at M+1.
- Write hit: MERGE at N+1, WB from N+2, last write beat at M → `mem_resp` at M+1.
- Write miss: FILL, then MERGE one cycle after the last read beat, then WB, then RESP.
- All outputs are decoded from registered state. There is no combinational path from `mem_read`/`mem_write` to `mem_resp`.

## Structure
- Shared package `line_buffer_types`:
  - Constants: `LINE_BITS=256`, `BEAT_BITS=64`, `BEATS=4`, `TAG_BITS=27`.
  - State enum: `lb_idle`, `lb_fill`, `lb_merge`, `lb_wb`, `lb_resp`.
- One sub-module, `line_buffer_array`:
  - Holds `valid`, `tag` and `data`.
  - Beat write port for fills.
  - Byte-enabled word write port for merges.
  - Word read port and beat read port.
  - Hit compare.
- The top level holds the FSM and `cnt`.

## Test plan
- **Read miss, then hit:**
  - After reset, read `0x00000064`. Require `pmem_read=1` and `pmem_address=0x00000060`.
  - Supply beats `0x1111111100000000`, `0x2222...`, `0x3333...`, `0x4444...`. Require `mem_resp` one cycle after beat 4 and `mem_rdata=0x11111111`.
  - Then read `0x00000070`. Require `mem_resp` in the next cycle, `mem_rdata=0x33333333` (word 4, low half of beat 2), and `pmem_read` never asserted.
- **Byte store, write hit:** on the loaded line, write `0x00000065` with `be=0010` and `wdata=0x0000AB00`.
  - Require a MERGE cycle, then `pmem_write` with beat 0 = `0x1111AB1100000000` and beats 1–3 unchanged.
  - A subsequent read of `0x64` returns `0x1111AB11`.
- **Write miss:** write `0x00001008`, `be=1111`, `wdata=0xDEADBEEF`.
  - Require a fill burst at `0x00001000`, then a write burst whose beat 1 low half is `0xDEADBEEF`, then one `mem_resp`.
- **Beat stalls:** during FILL, insert 3 idle cycles between beats 1 and 2. Require `cnt` to hold, `pmem_read` to stay 1, and the data to be correct after completion.
- **Reset mid-FILL:** assert `rst` after beat 2.
  - Require all outputs 0 in the same cycle and the FSM in IDLE.
  - A following read of the same address issues a new 4-beat fill.
- **Idle noise:** pulse `pmem_resp` in IDLE. Require no state change and no `mem_resp`.

Source files
------------

// File: rtl/line_buffer_pkg.sv
// Shared types and geometry for the single-entry line buffer.
// Contents:
//   LINE_BITS / BEAT_BITS / BEATS / TAG_BITS : fixed line and burst geometry
//   lb_state_e                               : controller state encoding
//   line_base()                              : line-aligned burst address from a tag
package line_buffer_types;

  localparam int LINE_BITS = 256;
  localparam int BEAT_BITS = 64;
  localparam int BEATS     = 4;
  localparam int TAG_BITS  = 27;

  typedef enum logic [2:0] {
    lb_idle  = 3'd0,
    lb_fill  = 3'd1,
    lb_merge = 3'd2,
    lb_wb    = 3'd3,
    lb_resp  = 3'd4
  } lb_state_e;

  // Burst address of the line holding a given tag (offset bits cleared).
  function automatic logic [31:0] line_base(input logic [TAG_BITS-1:0] tag);
    return {tag, 5'd0};
  endfunction

endpackage

// File: rtl/line_buffer_array.sv
// Storage for the single buffered line: valid bit, tag and 256 data bits.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   fill_we/fill_idx    : write one 64-bit beat (fill_data) at beat slot fill_idx
//   fill_last/fill_tag  : with fill_we, marks the line valid under fill_tag
//   merge_we            : byte-enabled write of merge_data into word word_idx
//   word_idx/rd_word    : word select shared by the merge port and the word read port
//   beat_idx/rd_beat    : beat read port feeding write-back bursts
//   lookup_tag/hit      : hit compare against the stored tag
module line_buffer_array
  import line_buffer_types::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fill_we,
  input  logic [1:0]           fill_idx,
  input  logic [BEAT_BITS-1:0] fill_data,
  input  logic                 fill_last,
  input  logic [TAG_BITS-1:0]  fill_tag,
  input  logic                 merge_we,
  input  logic [2:0]           word_idx,
  input  logic [3:0]           byte_en,
  input  logic [31:0]          merge_data,
  input  logic [TAG_BITS-1:0]  lookup_tag,
  output logic                 hit,
  output logic [31:0]          rd_word,
  input  logic [1:0]           beat_idx,
  output logic [BEAT_BITS-1:0] rd_beat
);

  logic                 valid_r;
  logic [TAG_BITS-1:0]  tag_r;
  logic [LINE_BITS-1:0] data_r;

  // Line storage: beat writes during fills, byte merges during stores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      tag_r   <= {TAG_BITS{1'b0}};
      data_r  <= {LINE_BITS{1'b0}};
    end else begin
      if (fill_we) begin
        data_r[{fill_idx, 6'd0} +: BEAT_BITS] <= fill_data;
      end else if (merge_we) begin
        for (int i = 0; i < 4; i++) begin
          if (byte_en[i]) begin
            data_r[{word_idx, 2'(i), 3'd0} +: 8] <= merge_data[8*i +: 8];
          end
        end
      end
      // The tag only becomes valid once the whole line has arrived.
      if (fill_we && fill_last) begin
        valid_r <= 1'b1;
        tag_r   <= fill_tag;
      end
    end
  end

  assign hit     = valid_r && (tag_r == lookup_tag);
  assign rd_word = data_r[{word_idx, 5'd0} +: 32];
  assign rd_beat = data_r[{beat_idx, 6'd0} +: BEAT_BITS];

endmodule

// File: rtl/line_buffer.sv
// Single-entry 256-bit line buffer between a 32-bit CPU word port and a
// 64-bit, 4-beat burst memory. Read hits answer in one cycle, misses fill
// the line; writes merge into the line and write the whole line back.
// Ports:
//   clk, rst                          : clock, asynchronous active-high reset
//   mem_address/mem_read/mem_write    : CPU request, held until mem_resp
//   mem_byte_enable/mem_wdata         : CPU store lanes and lane-aligned data
//   mem_rdata/mem_resp                : selected buffer word, one-cycle completion
//   pmem_address/pmem_read/pmem_write : burst request, held for the whole burst
//   pmem_wdata/pmem_rdata/pmem_resp   : burst beat data and per-beat handshake
module line_buffer
  import line_buffer_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic [31:0] pmem_address,
  output logic        pmem_read,
  output logic        pmem_write,
  output logic [63:0] pmem_wdata,
  input  logic [63:0] pmem_rdata,
  input  logic        pmem_resp
);

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  lb_state_e     state_r;
  logic [1:0]    cnt_r;
  logic          mem_resp_r;
  logic          pmem_read_r;
  logic          pmem_write_r;
  logic [31:0]   pmem_address_r;

  logic          hit_s;
  logic          fill_we_s;
  logic          merge_we_s;
  logic [31:0]   rd_word_s;
  logic [63:0]   rd_beat_s;
  logic [31:0]   line_addr_s;
  logic          addr_unused_s;

  // Byte offset within the word plays no part in word-granular buffering.
  assign addr_unused_s = ^mem_address[1:0];

  assign line_addr_s = line_base(mem_address[31:5]);
  assign fill_we_s   = (state_r == lb_fill) && pmem_resp;
  assign merge_we_s  = (state_r == lb_merge);

  line_buffer_array u_array (
    .clk        (clk),
    .rst        (rst),
    .fill_we    (fill_we_s),
    .fill_idx   (cnt_r),
    .fill_data  (pmem_rdata),
    .fill_last  (cnt_r == LAST_BEAT),
    .fill_tag   (mem_address[31:5]),
    .merge_we   (merge_we_s),
    .word_idx   (mem_address[4:2]),
    .byte_en    (mem_byte_enable),
    .merge_data (mem_wdata),
    .lookup_tag (mem_address[31:5]),
    .hit        (hit_s),
    .rd_word    (rd_word_s),
    .beat_idx   (cnt_r),
    .rd_beat    (rd_beat_s)
  );

  // Controller FSM; each handshake output is set on the transition into the
  // state that owns it, so all outputs come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= lb_idle;
      cnt_r          <= 2'd0;
      mem_resp_r     <= 1'b0;
      pmem_read_r    <= 1'b0;
      pmem_write_r   <= 1'b0;
      pmem_address_r <= 32'd0;
    end else begin
      case (state_r)
        lb_idle: begin
          // Writes win over a simultaneous read.
          if (mem_write) begin
            if (hit_s) begin
              state_r <= lb_merge;
            end else begin
              state_r        <= lb_fill;
              pmem_read_r    <= 1'b1;
              pmem_address_r <= line_addr_s;
            end
          end else if (mem_read) begin
            if (hit_s) begin
              state_r    <= lb_resp;
              mem_resp_r <= 1'b1;
            end else begin
              state_r        <= lb_fill;
              pmem_read_r    <= 1'b1;
              pmem_address_r <= line_addr_s;
            end
          end else begin
            state_r <= lb_idle;
          end
        end
        lb_fill: begin
          // Beats may arrive with gaps; everything holds while pmem_resp is low.
          if (pmem_resp) begin
            if (cnt_r == LAST_BEAT) begin
              cnt_r          <= 2'd0;
              pmem_read_r    <= 1'b0;
              pmem_address_r <= 32'd0;
              if (mem_write) begin
                state_r <= lb_merge;
              end else begin
                state_r    <= lb_resp;
                mem_resp_r <= 1'b1;
              end
            end else begin
              cnt_r <= cnt_r + 2'd1;
            end
          end
        end
        lb_merge: begin
          state_r        <= lb_wb;
          pmem_write_r   <= 1'b1;
          pmem_address_r <= line_addr_s;
        end
        lb_wb: begin
          if (pmem_resp) begin
            if (cnt_r == LAST_BEAT) begin
              cnt_r          <= 2'd0;
              pmem_write_r   <= 1'b0;
              pmem_address_r <= 32'd0;
              state_r        <= lb_resp;
              mem_resp_r     <= 1'b1;
            end else begin
              cnt_r <= cnt_r + 2'd1;
            end
          end
        end
        lb_resp: begin
          state_r    <= lb_idle;
          mem_resp_r <= 1'b0;
        end
        default: begin
          state_r        <= lb_idle;
          cnt_r          <= 2'd0;
          mem_resp_r     <= 1'b0;
          pmem_read_r    <= 1'b0;
          pmem_write_r   <= 1'b0;
          pmem_address_r <= 32'd0;
        end
      endcase
    end
  end

  assign mem_resp     = mem_resp_r;
  assign mem_rdata    = rd_word_s;
  assign pmem_read    = pmem_read_r;
  assign pmem_write   = pmem_write_r;
  assign pmem_address = pmem_address_r;
  // Beat data is only driven while a write burst is in flight.
  assign pmem_wdata   = pmem_write_r ? rd_beat_s : 64'd0;

endmodule

// File: tb/tb_line_buffer.sv
// Self-checking bench for line_buffer: directed vector table, hand-written
// corner sequences (stalls, reset mid-fill, idle noise) and randomized
// traffic against a word-array reference model with a burst memory model.
module tb_line_buffer;
  import line_buffer_types::*;

  logic        clk;
  logic        rst;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic [31:0] pmem_address;
  logic        pmem_read;
  logic        pmem_write;
  logic [63:0] pmem_wdata;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;

  int checks = 0;
  int errors = 0;

  line_buffer dut (
    .clk             (clk),
    .rst             (rst),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one buffered line as 8 words, plus backing memory by beat address.
  logic        valid_m;
  logic [26:0] tag_m;
  logic [31:0] line_m [8];
  logic [63:0] pmem_m [logic [31:0]];

  function automatic logic [63:0] mem_beat(input logic [31:0] a);
    if (pmem_m.exists(a)) return pmem_m[a];
    else return {a ^ 32'h5A5A_0000, ~a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    valid_m = 1'b0;
    tag_m   = 27'd0;
    for (int w = 0; w < 8; w++) line_m[w] = 32'd0;
  endtask

  // stall_mode: 0 = no gaps, 1 = random gaps, 2 = three idle cycles after fill beat 1.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input int stall_mode,
                        output logic [31:0] rdata_o, output logic saw_fill, output logic saw_wb);
    logic        hit;
    logic [31:0] base;
    logic [63:0] fill_exp [4];
    logic [63:0] wb_exp [4];
    int          fbeats, wbeats, stalls, cycles, gap, exp_cycles;
    logic        done, give;
    hit = valid_m && (tag_m == addr[31:5]);
    base = {addr[31:5], 5'd0};
    for (int b = 0; b < 4; b++) fill_exp[b] = mem_beat(base + 32'(8*b));
    if (!hit) begin
      for (int b = 0; b < 4; b++) begin
        line_m[2*b]   = fill_exp[b][31:0];
        line_m[2*b+1] = fill_exp[b][63:32];
      end
      valid_m = 1'b1;
      tag_m   = addr[31:5];
    end
    if (wr) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) line_m[addr[4:2]][8*i +: 8] = wd[8*i +: 8];
    end
    for (int b = 0; b < 4; b++) wb_exp[b] = {line_m[2*b+1], line_m[2*b]};
    fbeats = 0; wbeats = 0; stalls = 0; cycles = 0; gap = 0; done = 1'b0;
    saw_fill = 1'b0; saw_wb = 1'b0; rdata_o = 32'd0;
    mem_address = addr; mem_read = !wr; mem_write = wr;
    mem_byte_enable = be; mem_wdata = wd;
    for (int c = 0; c < 300 && !done; c++) begin
      @(posedge clk); #1;
      cycles++;
      pmem_resp = 1'b0;
      if (mem_resp) begin
        rdata_o = mem_rdata;
        done = 1'b1;
      end else if (pmem_read || pmem_write) begin
        chk("burst address", pmem_address, base);
        if (pmem_read && pmem_write) chk("read and write together", 1, 0);
        case (stall_mode)
          1: give = ($urandom_range(0, 2) != 0);
          2: begin
            if (pmem_read && fbeats == 1 && gap < 3) begin
              give = 1'b0;
              gap++;
              chk("cnt holds in stall", dut.cnt_r, 2'd1);
            end else give = 1'b1;
          end
          default: give = 1'b1;
        endcase
        if (!give) stalls++;
        else if (pmem_read) begin
          saw_fill = 1'b1;
          if (fbeats < 4) pmem_rdata = fill_exp[fbeats];
          fbeats++;
          pmem_resp = 1'b1;
        end else begin
          saw_wb = 1'b1;
          if (wbeats < 4) chk("write beat", pmem_wdata, wb_exp[wbeats]);
          wbeats++;
          pmem_resp = 1'b1;
        end
      end
    end
    chk("resp seen before timeout", done, 1'b1);
    mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    exp_cycles = 1 + (hit ? 0 : 4) + (wr ? 5 : 0) + stalls;
    chk("fill beats", fbeats, hit ? 0 : 4);
    chk("write beats", wbeats, wr ? 4 : 0);
    chk("latency", cycles, exp_cycles);
    chk("rdata", rdata_o, line_m[addr[4:2]]);
    @(posedge clk); #1;
    chk("resp single cycle", mem_resp, 1'b0);
    if (wr) for (int b = 0; b < 4; b++) pmem_m[base + 32'(8*b)] = wb_exp[b];
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp_rdata;
    logic        exp_fill;
    logic        exp_wb;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        sf, sw;
    int          given;

    vecs[0] = '{1'b0, 32'h0000_0064, 4'b0000, 32'd0,          32'h1111_1111, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 32'h0000_0070, 4'b0000, 32'd0,          32'h3333_3333, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'h0000_0065, 4'b0010, 32'h0000_AB00,  32'h1111_AB11, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 32'h0000_0064, 4'b0000, 32'd0,          32'h1111_AB11, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 32'h0000_1008, 4'b1111, 32'hDEAD_BEEF,  32'hDEAD_BEEF, 1'b1, 1'b1};

    pmem_m[32'h60] = 64'h1111_1111_0000_0000;
    pmem_m[32'h68] = 64'h2222_2222_2222_2222;
    pmem_m[32'h70] = 64'h3333_3333_3333_3333;
    pmem_m[32'h78] = 64'h4444_4444_4444_4444;

    rst = 1'b1; mem_address = 32'd0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = 4'd0; mem_wdata = 32'd0; pmem_rdata = 64'd0; pmem_resp = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset mem_resp", mem_resp, 1'b0);
    chk("reset pmem_read", pmem_read, 1'b0);
    chk("reset pmem_write", pmem_write, 1'b0);
    chk("reset pmem_address", pmem_address, 32'd0);
    chk("reset mem_rdata", mem_rdata, 32'd0);
    rst = 1'b0;

    // Directed vectors from the table.
    for (int i = 0; i < 5; i++) begin
      do_req(vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wd, 0, rd, sf, sw);
      chk("vec rdata", rd, vecs[i].exp_rdata);
      chk("vec fill", sf, vecs[i].exp_fill);
      chk("vec writeback", sw, vecs[i].exp_wb);
    end
    chk("line 0x60 beat0 in memory", pmem_m[32'h60], 64'h1111_AB11_0000_0000);
    chk("line 0x60 beat1 in memory", pmem_m[32'h68], 64'h2222_2222_2222_2222);

    // Idle noise: stray pmem_resp with no request.
    for (int c = 0; c < 3; c++) begin
      pmem_resp = 1'b1;
      @(posedge clk); #1;
      chk("idle noise mem_resp", mem_resp, 1'b0);
      chk("idle noise pmem_read", pmem_read, 1'b0);
      chk("idle noise state", dut.state_r, lb_idle);
    end
    pmem_resp = 1'b0;
    do_req(1'b0, 32'h0000_100C, 4'd0, 32'd0, 0, rd, sf, sw);
    chk("hit after noise fill", sf, 1'b0);
    do_req(1'b0, 32'h0000_0860, 4'd0, 32'd0, 0, rd, sf, sw);
    chk("miss after noise fill", sf, 1'b1);

    // Beat stalls between beats 1 and 2.
    do_req(1'b0, 32'h0000_2014, 4'd0, 32'd0, 2, rd, sf, sw);
    chk("stall rdata", rd, mem_beat(32'h2010) >> 32);

    // Reset in the middle of a fill.
    mem_address = 32'h0000_3004; mem_read = 1'b1; given = 0;
    for (int c = 0; c < 20 && given < 2; c++) begin
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      if (pmem_read) begin
        pmem_rdata = mem_beat(32'h3000 + 32'(8*given));
        pmem_resp = 1'b1;
        given++;
      end
    end
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    chk("two beats before reset", given, 2);
    chk("fill still running", pmem_read, 1'b1);
    rst = 1'b1; mem_read = 1'b0;
    #1;
    chk("midfill rst pmem_read", pmem_read, 1'b0);
    chk("midfill rst pmem_write", pmem_write, 1'b0);
    chk("midfill rst pmem_address", pmem_address, 32'd0);
    chk("midfill rst pmem_wdata", pmem_wdata, 64'd0);
    chk("midfill rst mem_resp", mem_resp, 1'b0);
    chk("midfill rst mem_rdata", mem_rdata, 32'd0);
    chk("midfill rst state", dut.state_r, lb_idle);
    chk("midfill rst cnt", dut.cnt_r, 2'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    do_req(1'b0, 32'h0000_3004, 4'd0, 32'd0, 0, rd, sf, sw);
    chk("refill after reset", sf, 1'b1);

    // Randomized traffic over a few lines with random beat gaps.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = 32'h4000 + 32'($urandom_range(0, 2) * 32) + 32'($urandom_range(0, 31));
      do_req(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, 1, rd, sf, sw);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
